mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter_if.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Port bundle for mem_bus_arbiter: fetch port, load/store port, memory bus and stall requests.
// The master modport is the arbiter; the slave modport is the requesters and memory around it.
interface mem_bus_arbiter_if;
   logic        inst_ce;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        inst_ready;

   logic        data_ce;
   logic        data_we;
   logic [3:0]  data_sel;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_ready;

   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   logic        stall_req_if;
   logic        stall_req_mem;

   modport master (
      input  inst_ce, inst_addr,
      input  data_ce, data_we, data_sel, data_addr, data_wdata,
      input  bus_rdata, bus_ack,
      output inst_data, inst_ready,
      output data_rdata, data_ready,
      output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
      output stall_req_if, stall_req_mem
   );

   modport slave (
      output inst_ce, inst_addr,
      output data_ce, data_we, data_sel, data_addr, data_wdata,
      output bus_rdata, bus_ack,
      input  inst_data, inst_ready,
      input  data_rdata, data_ready,
      input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
      input  stall_req_if, stall_req_mem
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between the fetch port and the load/store port.
// Data has priority, a starvation counter bounds fetch waiting, and hung transactions time out.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT_CYC  = 64
) (
   input logic               clk,
   input logic               rst,
   mem_bus_arbiter_if.master bif
);
   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_INC   = SW'(1'b1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_INC  = TW'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t        state_r;
   logic          bus_req_r;
   logic          bus_we_r;
   logic [3:0]    bus_sel_r;
   logic [31:0]   bus_addr_r;
   logic [31:0]   bus_wdata_r;
   logic          bus_err_r;
   logic          inst_ready_r;
   logic          data_ready_r;
   logic [31:0]   inst_data_r;
   logic [31:0]   data_rdata_r;
   logic [SW-1:0] starve_cnt_r;
   logic [TW-1:0] timeout_cnt_r;

   logic          inst_elig_s;
   logic          data_elig_s;
   logic          grant_i_s;
   logic          grant_d_s;

   // Eligibility masks a port in its own completion cycle so a held ce is not re-issued early.
   always_comb begin
      inst_elig_s = bif.inst_ce & ~inst_ready_r;
      data_elig_s = bif.data_ce & ~data_ready_r;
      grant_i_s   = 1'b0;
      grant_d_s   = 1'b0;
      if (data_elig_s && !(inst_elig_s && (starve_cnt_r == STARVE_MAX))) begin
         grant_d_s = 1'b1;
      end else if (inst_elig_s) begin
         grant_i_s = 1'b1;
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Transaction sequencer: grant, hold the bus until ack or timeout, then pulse ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         bus_req_r     <= 1'b0;
         bus_we_r      <= 1'b0;
         bus_sel_r     <= 4'h0;
         bus_addr_r    <= 32'h0000_0000;
         bus_wdata_r   <= 32'h0000_0000;
         bus_err_r     <= 1'b0;
         inst_ready_r  <= 1'b0;
         data_ready_r  <= 1'b0;
         inst_data_r   <= 32'h0000_0000;
         data_rdata_r  <= 32'h0000_0000;
         starve_cnt_r  <= {SW{1'b0}};
         timeout_cnt_r <= {TW{1'b0}};
      end else begin
         inst_ready_r <= 1'b0;
         data_ready_r <= 1'b0;
         bus_err_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_i_s) begin
                  bus_req_r     <= 1'b1;
                  bus_we_r      <= 1'b0;
                  bus_sel_r     <= 4'hF;
                  bus_addr_r    <= bif.inst_addr;
                  bus_wdata_r   <= 32'h0000_0000;
                  timeout_cnt_r <= {TW{1'b0}};
                  starve_cnt_r  <= {SW{1'b0}};
                  state_r       <= ST_BUSY_I;
               end else if (grant_d_s) begin
                  bus_req_r     <= 1'b1;
                  bus_we_r      <= bif.data_we;
                  bus_sel_r     <= bif.data_sel;
                  bus_addr_r    <= bif.data_addr;
                  bus_wdata_r   <= bif.data_wdata;
                  timeout_cnt_r <= {TW{1'b0}};
                  state_r       <= ST_BUSY_D;
                  // Only data grants that overtake a waiting fetch count toward starvation.
                  if (!bif.inst_ce) begin
                     starve_cnt_r <= {SW{1'b0}};
                  end else if (starve_cnt_r != STARVE_MAX) begin
                     starve_cnt_r <= starve_cnt_r + STARVE_INC;
                  end else begin
                     starve_cnt_r <= starve_cnt_r;
                  end
               end else begin
                  if (!bif.inst_ce) begin
                     starve_cnt_r <= {SW{1'b0}};
                  end else begin
                     starve_cnt_r <= starve_cnt_r;
                  end
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               // An ack in the final timeout cycle still completes normally.
               if (bif.bus_ack) begin
                  bus_req_r <= 1'b0;
                  state_r   <= ST_IDLE;
                  if (state_r == ST_BUSY_I) begin
                     inst_data_r  <= bif.bus_rdata;
                     inst_ready_r <= 1'b1;
                  end else begin
                     data_rdata_r <= bus_we_r ? 32'h0000_0000 : bif.bus_rdata;
                     data_ready_r <= 1'b1;
                  end
               end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                  bus_req_r <= 1'b0;
                  bus_err_r <= 1'b1;
                  state_r   <= ST_IDLE;
                  if (state_r == ST_BUSY_I) begin
                     inst_data_r  <= 32'h0000_0000;
                     inst_ready_r <= 1'b1;
                  end else begin
                     data_rdata_r <= 32'h0000_0000;
                     data_ready_r <= 1'b1;
                  end
               end else begin
                  timeout_cnt_r <= timeout_cnt_r + TIMEOUT_INC;
               end
            end
            default: begin
               bus_req_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bif.bus_req       = bus_req_r;
   assign bif.bus_we        = bus_we_r;
   assign bif.bus_sel       = bus_sel_r;
   assign bif.bus_addr      = bus_addr_r;
   assign bif.bus_wdata     = bus_wdata_r;
   assign bif.bus_err       = bus_err_r;
   assign bif.inst_ready    = inst_ready_r;
   assign bif.data_ready    = data_ready_r;
   assign bif.inst_data     = inst_data_r;
   assign bif.data_rdata    = data_rdata_r;
   assign bif.stall_req_if  = bif.inst_ce & ~inst_ready_r;
   assign bif.stall_req_mem = bif.data_ce & ~data_ready_r;
endmodule
